// File: rtl/write_bridge_sched.sv
// ----------------------------------------------------------------------------
// write_bridge_sched
//
// Command-level sequencer placed in front of the multi-channel HBM write
// bridge. A single transfer command (start byte offset, total wide beats) is
// split into AXI-legal bursts. Each burst is at most MAX_BURST beats and never
// crosses a BOUNDARY-byte boundary. For each burst the block first completes
// the bridge's ctrl AW handshake. It then meters exactly that burst's beats
// from the upstream wide stream into the bridge's ctrl W handshake. The data
// path is a zero-latency pass-through.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       transfer request; ready only while idle
//   cmd_addr                  start byte offset (bits [5:0] ignored)
//   cmd_beats                 total wide beats (0 is legal)
//   src_valid/src_ready       upstream wide beat handshake
//   src_data                  upstream wide beat
//   ctrl_awvalid/awready      per-burst address handshake to the bridge
//   ctrl_awaddr, ctrl_awlen   burst start address and length-1
//   ctrl_wvalid/wready        per-beat data handshake to the bridge
//   ctrl_wdata                wide beat to the bridge (= src_data)
//   busy                      transfer in progress
//   done                      one-cycle pulse once every beat has been
//                             accepted by the bridge
//   burst_cnt                 bursts issued in the current/last transfer
// ----------------------------------------------------------------------------
module write_bridge_sched #(
    parameter int NUM_BRIDGE         = 16,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int MAX_BURST          = 64,
    parameter int BOUNDARY           = 4096
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]             cmd_addr,
    input  logic [31:0]                               cmd_beats,
    input  logic                                      src_valid,
    input  logic [NUM_BRIDGE*C_M_AXI_DATA_WIDTH-1:0]  src_data,
    output logic                                      src_ready,
    output logic                                      ctrl_awvalid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]             ctrl_awaddr,
    output logic [7:0]                                ctrl_awlen,
    input  logic                                      ctrl_awready,
    output logic                                      ctrl_wvalid,
    output logic [NUM_BRIDGE*C_M_AXI_DATA_WIDTH-1:0]  ctrl_wdata,
    input  logic                                      ctrl_wready,
    output logic                                      busy,
    output logic                                      done,
    output logic [15:0]                               burst_cnt
);

    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    // Address bits covering one boundary window.
    localparam int BW  = $clog2(BOUNDARY);
    // Width that can hold BOUNDARY/64 (beats in a full window).
    localparam int TBW = BW - 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [AW-1:0]   r_addr;       // byte address of the next burst
    logic [31:0]     r_rem;        // beats still to hand to the bridge
    logic [8:0]      r_blen;       // length of the current burst
    logic [8:0]      r_bcnt;       // beats left in the current burst
    logic [AW-1:0]   r_awaddr;
    logic [7:0]      r_awlen;
    logic [15:0]     r_burst_cnt;

    logic [BW-7:0]   w_off_beats;  // beat offset within the boundary window
    logic [TBW-1:0]  w_to_bound;   // beats until the next boundary (>= 1)
    logic [8:0]      w_cap;        // min(MAX_BURST, w_to_bound)
    logic [8:0]      w_blen;       // min(r_rem, w_cap)
    logic            w_in_data;
    logic            w_aw_hs;
    logic            w_w_hs;

    // ---------------------------------------------------------------------
    // Burst length: limited by the remaining beats, MAX_BURST and the
    // distance to the next boundary. r_addr is always 64-byte aligned, so
    // the distance is measured in whole beats.
    // ---------------------------------------------------------------------
    assign w_off_beats = r_addr[BW-1:6];
    assign w_to_bound  = TBW'(BOUNDARY / 64) - {1'b0, w_off_beats};
    assign w_cap       = (32'(w_to_bound) > 32'(MAX_BURST)) ? 9'(MAX_BURST)
                                                            : 9'(w_to_bound);
    assign w_blen      = (r_rem < {23'd0, w_cap}) ? r_rem[8:0] : w_cap;

    // ---------------------------------------------------------------------
    // Handshakes and outputs derived from state. Beats can only flow while
    // in DATA, so a later burst's data never reaches the bridge before its
    // address handshake has completed.
    // ---------------------------------------------------------------------
    assign w_in_data    = (r_state == S_DATA);
    assign w_aw_hs      = ctrl_awvalid & ctrl_awready;
    assign w_w_hs       = w_in_data & src_valid & ctrl_wready;

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign ctrl_awvalid = (r_state == S_ADDR);
    assign ctrl_awaddr  = r_awaddr;
    assign ctrl_awlen   = r_awlen;
    assign ctrl_wvalid  = w_in_data & src_valid;
    assign src_ready    = w_in_data & ctrl_wready;
    assign ctrl_wdata   = src_data;
    assign burst_cnt    = r_burst_cnt;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_next = (cmd_beats == 32'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = S_ADDR;
            end
            S_ADDR: begin
                if (w_aw_hs) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                // Last beat of the burst: r_rem==1 means nothing remains
                // after this beat.
                if (w_w_hs && (r_bcnt == 9'd1)) begin
                    w_state_next = (r_rem == 32'd1) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_rem       <= '0;
            r_blen      <= '0;
            r_bcnt      <= '0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // The low six bits select a byte within a 64 B beat
                        // and are dropped.
                        r_addr      <= cmd_addr & ~(AW'(64) - AW'(1));
                        r_rem       <= cmd_beats;
                        r_burst_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_awaddr <= r_addr;
                    r_awlen  <= 8'(w_blen - 9'd1);
                    r_blen   <= w_blen;
                    r_bcnt   <= w_blen;
                end
                S_ADDR: begin
                    if (w_aw_hs) begin
                        r_burst_cnt <= r_burst_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_w_hs) begin
                        r_bcnt <= r_bcnt - 9'd1;
                        r_rem  <= r_rem - 32'd1;
                        if (r_bcnt == 9'd1) begin
                            // Address wraps naturally at the top of the space.
                            r_addr <= r_addr + (AW'(r_blen) << 6);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
